// File: rtl/id_stage_hz.sv
// MIPS decode stage: register file, ID-stage branch resolution with forwarding,
// hazard/stall detection and the ID/EX register. ID_STAGE_PERF_EN adds stall/branch counters.
module id_stage_hz #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5,
    parameter int ADDR_W   = 32,
    parameter int CTRL_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [31:0]       in_instr,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              is_branch,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_dst,
    input  logic              mem_reg_write,
    input  logic              mem_mem_read,
    input  logic [REG_AW-1:0] mem_dst,
    input  logic [DATA_W-1:0] mem_alu,
    input  logic              flush_ex,
    output logic              stall,
    output logic              pc_src,
    output logic [ADDR_W-1:0] branch_target,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_rs_data,
    output logic [DATA_W-1:0] out_rt_data,
    output logic [DATA_W-1:0] out_imm,
    output logic [REG_AW-1:0] out_rs,
    output logic [REG_AW-1:0] out_rt,
    output logic [REG_AW-1:0] out_rd,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef ID_STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       br_taken_cnt
`endif
);

    logic [5:0]        opcode;
    logic [REG_AW-1:0] rs_idx, rt_idx, rd_idx;
    logic [15:0]       imm16;

    assign opcode = in_instr[31:26];
    assign rs_idx = in_instr[21 +: REG_AW];
    assign rt_idx = in_instr[16 +: REG_AW];
    assign rd_idx = in_instr[11 +: REG_AW];
    assign imm16  = in_instr[15:0];

    logic [DATA_W-1:0] rf_q [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
        end else if (wb_we && wb_addr != '0) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    // Read ports see a same-cycle writeback; index 0 is hard zero.
    logic [DATA_W-1:0] rs_val, rt_val;

    always_comb begin
        rs_val = '0;
        rt_val = '0;
        if (rs_idx != '0) rs_val = (wb_we && wb_addr == rs_idx) ? wb_data : rf_q[rs_idx];
        if (rt_idx != '0) rt_val = (wb_we && wb_addr == rt_idx) ? wb_data : rf_q[rt_idx];
    end

    logic ex_match, mem_match, stall_cond;

    assign ex_match  = (ex_dst != '0)  && (ex_dst == rs_idx || ex_dst == rt_idx);
    assign mem_match = (mem_dst != '0) && (mem_dst == rs_idx || mem_dst == rt_idx);

    assign stall_cond = (ex_mem_read && ex_match) ||
                        (is_branch && ((ex_reg_write && ex_match) || (mem_mem_read && mem_match)));
    assign stall = in_valid && stall_cond;

    logic              mem_fwd_ok;
    logic [DATA_W-1:0] br_a, br_b;
    logic              br_cond;

    assign mem_fwd_ok = mem_reg_write && !mem_mem_read && (mem_dst != '0);
    assign br_a = (mem_fwd_ok && mem_dst == rs_idx) ? mem_alu : rs_val;
    assign br_b = (mem_fwd_ok && mem_dst == rt_idx) ? mem_alu : rt_val;

    always_comb begin
        br_cond = 1'b0;
        case (opcode)
            6'b000100: br_cond = (br_a == br_b);
            6'b000101: br_cond = (br_a != br_b);
            6'b000110: br_cond = br_a[DATA_W-1] || (br_a == '0);
            6'b000111: br_cond = !br_a[DATA_W-1] && (br_a != '0);
            default:   br_cond = 1'b0;
        endcase
    end

    assign pc_src = in_valid && is_branch && !stall && br_cond;

    logic [ADDR_W-1:0] br_off;
    assign br_off        = ADDR_W'($signed(imm16)) << 2;
    assign branch_target = in_pc + br_off;

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
    logic [REG_AW-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              capture;

    // Bubbles clear only valid and ctrl; the data fields keep their old contents.
    assign capture = in_valid && !stall && !flush_ex;

    always_comb begin
        valid_d   = capture;
        ctrl_d    = capture ? ctrl_in : '0;
        pc_d      = capture ? in_pc   : pc_q;
        rs_data_d = capture ? rs_val  : rs_data_q;
        rt_data_d = capture ? rt_val  : rt_data_q;
        imm_d     = capture ? DATA_W'($signed(imm16)) : imm_q;
        rs_d      = capture ? rs_idx  : rs_q;
        rt_d      = capture ? rt_idx  : rt_q;
        rd_d      = capture ? rd_idx  : rd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            pc_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            pc_q      <= pc_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_ctrl    = ctrl_q;
    assign out_pc      = pc_q;
    assign out_rs_data = rs_data_q;
    assign out_rt_data = rt_data_q;
    assign out_imm     = imm_q;
    assign out_rs      = rs_q;
    assign out_rt      = rt_q;
    assign out_rd      = rd_q;

`ifdef ID_STAGE_PERF_EN
    logic [31:0] stall_cnt_q, br_taken_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q    <= '0;
            br_taken_cnt_q <= '0;
        end else begin
            if (stall && stall_cnt_q != '1)     stall_cnt_q    <= stall_cnt_q + 32'd1;
            if (pc_src && br_taken_cnt_q != '1) br_taken_cnt_q <= br_taken_cnt_q + 32'd1;
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign br_taken_cnt = br_taken_cnt_q;
`endif

endmodule

// File: tb/tb_id_stage_hz.sv
// Scoreboard bench for id_stage_hz: expected ID/EX contents are queued at drive
// time and compared after the capturing edge; combinational outputs checked inline.
module tb_id_stage_hz;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [15:0] ctrl_in;
    logic        is_branch;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic [4:0]  ex_dst;
    logic        mem_reg_write;
    logic        mem_mem_read;
    logic [4:0]  mem_dst;
    logic [31:0] mem_alu;
    logic        flush_ex;
    logic        stall;
    logic        pc_src;
    logic [31:0] branch_target;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_rs_data;
    logic [31:0] out_rt_data;
    logic [31:0] out_imm;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [4:0]  out_rd;
    logic [15:0] out_ctrl;
`ifdef ID_STAGE_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] br_taken_cnt;
`endif

    id_stage_hz #(
        .DATA_W  (32),
        .NUM_REGS(32),
        .REG_AW  (5),
        .ADDR_W  (32),
        .CTRL_W  (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .ctrl_in      (ctrl_in),
        .is_branch    (is_branch),
        .wb_we        (wb_we),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .ex_dst       (ex_dst),
        .mem_reg_write(mem_reg_write),
        .mem_mem_read (mem_mem_read),
        .mem_dst      (mem_dst),
        .mem_alu      (mem_alu),
        .flush_ex     (flush_ex),
        .stall        (stall),
        .pc_src       (pc_src),
        .branch_target(branch_target),
        .out_valid    (out_valid),
        .out_pc       (out_pc),
        .out_rs_data  (out_rs_data),
        .out_rt_data  (out_rt_data),
        .out_imm      (out_imm),
        .out_rs       (out_rs),
        .out_rt       (out_rt),
        .out_rd       (out_rd),
        .out_ctrl     (out_ctrl)
`ifdef ID_STAGE_PERF_EN
        ,
        .stall_cnt    (stall_cnt),
        .br_taken_cnt (br_taken_cnt)
`endif
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] ctrl;
    } idex_t;

    idex_t sb[$];
    idex_t last;
    idex_t exp_e;
    idex_t act;
    int    n_checks = 0;
    int    n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic idex_t idex_now();
        return {out_valid, out_pc, out_rs_data, out_rt_data, out_imm, out_rs, out_rt, out_rd, out_ctrl};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_instr = '0; in_pc = '0; ctrl_in = '0; is_branch = 1'b0;
        wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_dst = '0;
        mem_reg_write = 1'b0; mem_mem_read = 1'b0; mem_dst = '0; mem_alu = '0;
        flush_ex = 1'b0;
    endtask

    task automatic push_cap(input logic [31:0] pc, input logic [31:0] rsd, input logic [31:0] rtd,
                            input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [15:0] ctrl);
        last = {1'b1, pc, rsd, rtd, imm, rs, rt, rd, ctrl};
        sb.push_back(last);
    endtask

    task automatic push_bubble();
        last.valid = 1'b0;
        last.ctrl  = '0;
        sb.push_back(last);
    endtask

    // Idle cycle that writes the register file; ID/EX takes a bubble.
    task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
        idle();
        wb_we = 1'b1; wb_addr = a; wb_data = d;
        last.valid = 1'b0;
        last.ctrl  = '0;
        tick();
        wb_we = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        last  = '0;
        #2;
        act = idex_now(); n_checks++;
        if (act !== '0) begin n_fail++; $display("FAIL reset_idex: got %h want 0", act); end
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_checks++;
        if (pc_src !== 1'b0) begin n_fail++; $display("FAIL reset_pc_src: got %b want 0", pc_src); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        push_bubble();
        tick();
        exp_e = sb.pop_front(); act = idex_now(); n_checks++;
        if (act !== exp_e) begin n_fail++; $display("FAIL post_reset_idle: got %h want %h", act, exp_e); end
    endtask

    task automatic test_bypass();
        idle();
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
        in_valid = 1'b1; in_instr = mk(6'd0, 5'd5, 5'd0, 16'h1820); in_pc = 32'h40; ctrl_in = 16'h00A5;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL bypass_stall: got %b want 0", stall); end
        push_cap(32'h40, 32'h1234, 32'h0, 32'h1820, 5'd5, 5'd0, 5'd3, 16'h00A5);
        tick();
        exp_e = sb.pop_front(); act = idex_now(); n_checks++;
        if (act !== exp_e) begin n_fail++; $display("FAIL bypass_cap: got %h want %h", act, exp_e); end
        wb_we = 1'b0;
        in_instr = mk(6'd0, 5'd5, 5'd5, 16'h2000); in_pc = 32'h44; ctrl_in = 16'h005A;
        push_cap(32'h44, 32'h1234, 32'h1234, 32'h2000, 5'd5, 5'd5, 5'd4, 16'h005A);
        tick();
        exp_e = sb.pop_front(); act = idex_now(); n_checks++;
        if (act !== exp_e) begin n_fail++; $display("FAIL rf_read: got %h want %h", act, exp_e); end
    endtask

    task automatic test_load_use();
        wr_reg(5'd8, 32'h88);
        in_valid = 1'b1; in_instr = mk(6'd0, 5'd0, 5'd8, 16'h4800); in_pc = 32'h50; ctrl_in = 16'h0F0F;
        ex_mem_read = 1'b1; ex_dst = 5'd8;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL load_use_stall: got %b want 1", stall); end
        push_bubble();
        tick();
        exp_e = sb.pop_front(); act = idex_now(); n_checks++;
        if (act !== exp_e) begin n_fail++; $display("FAIL load_use_bubble: got %h want %h", act, exp_e); end
        ex_dst = 5'd0;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL load_reg0_nostall: got %b want 0", stall); end
        push_cap(32'h50, 32'h0, 32'h88, 32'h4800, 5'd0, 5'd8, 5'd9, 16'h0F0F);
        tick();
        exp_e = sb.pop_front(); act = idex_now(); n_checks++;
        if (act !== exp_e) begin n_fail++; $display("FAIL load_use_cap: got %h want %h", act, exp_e); end
`ifdef ID_STAGE_PERF_EN
        n_checks++;
        if (stall_cnt !== 32'd1) begin n_fail++; $display("FAIL perf_stall_cnt: got %0d want 1", stall_cnt); end
`endif
        idle();
    endtask

    task automatic test_beq_fwd();
        wr_reg(5'd1, 32'd3);
        in_valid = 1'b1; is_branch = 1'b1; in_instr = mk(6'b000100, 5'd1, 5'd2, 16'h0004);
        in_pc = 32'h100; ctrl_in = 16'h1111;
        mem_reg_write = 1'b1; mem_dst = 5'd2; mem_alu = 32'd3;
        #1;
        n_checks++;
        if (pc_src !== 1'b1) begin n_fail++; $display("FAIL beq_fwd_taken: got %b want 1", pc_src); end
        n_checks++;
        if (branch_target !== 32'h110) begin n_fail++; $display("FAIL beq_target: got %h want 00000110", branch_target); end
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL beq_stall: got %b want 0", stall); end
        in_instr = mk(6'b000101, 5'd1, 5'd2, 16'h0004);
        #1;
        n_checks++;
        if (pc_src !== 1'b0) begin n_fail++; $display("FAIL bne_fwd: got %b want 0", pc_src); end
        in_instr = mk(6'b000100, 5'd1, 5'd2, 16'h0004); mem_mem_read = 1'b1;
        #1;
        n_checks++;
        if ({stall, pc_src} !== 2'b10) begin n_fail++; $display("FAIL br_mem_load: got stall/pc_src %b want 10", {stall, pc_src}); end
        mem_mem_read = 1'b0; ex_reg_write = 1'b1; ex_dst = 5'd1;
        #1;
        n_checks++;
        if ({stall, pc_src} !== 2'b10) begin n_fail++; $display("FAIL br_ex_alu: got stall/pc_src %b want 10", {stall, pc_src}); end
        is_branch = 1'b0;
        #1;
        n_checks++;
        if ({stall, pc_src} !== 2'b00) begin n_fail++; $display("FAIL nonbr_ex_alu: got stall/pc_src %b want 00", {stall, pc_src}); end
        is_branch = 1'b1; ex_reg_write = 1'b0; ex_dst = 5'd0;
        push_cap(32'h100, 32'd3, 32'd0, 32'h4, 5'd1, 5'd2, 5'd0, 16'h1111);
        tick();
        exp_e = sb.pop_front(); act = idex_now(); n_checks++;
        if (act !== exp_e) begin n_fail++; $display("FAIL beq_cap: got %h want %h", act, exp_e); end
        idle();
    endtask

    task automatic test_bgtz();
        wr_reg(5'd3, 32'hFFFF_FFFF);
        wr_reg(5'd4, 32'd1);
        in_valid = 1'b1; is_branch = 1'b1; in_pc = 32'h200; ctrl_in = 16'h2222;
        in_instr = mk(6'b000111, 5'd3, 5'd0, 16'h0010);
        #1;
        n_checks++;
        if (pc_src !== 1'b0) begin n_fail++; $display("FAIL bgtz_neg: got %b want 0", pc_src); end
        in_instr = mk(6'b000110, 5'd3, 5'd0, 16'h0010);
        #1;
        n_checks++;
        if (pc_src !== 1'b1) begin n_fail++; $display("FAIL blez_neg: got %b want 1", pc_src); end
        in_instr = mk(6'b000001, 5'd4, 5'd0, 16'hFFFF);
        #1;
        n_checks++;
        if (pc_src !== 1'b0) begin n_fail++; $display("FAIL br_other_op: got %b want 0", pc_src); end
        in_instr = mk(6'b000111, 5'd4, 5'd0, 16'hFFFF);
        #1;
        n_checks++;
        if (pc_src !== 1'b1) begin n_fail++; $display("FAIL bgtz_pos: got %b want 1", pc_src); end
        n_checks++;
        if (branch_target !== 32'h1FC) begin n_fail++; $display("FAIL bgtz_target: got %h want 000001fc", branch_target); end
        in_pc = 32'h0;
        #1;
        n_checks++;
        if (branch_target !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL target_wrap: got %h want fffffffc", branch_target); end
        in_pc = 32'h200;
        push_cap(32'h200, 32'd1, 32'd0, 32'hFFFF_FFFF, 5'd4, 5'd0, 5'd31, 16'h2222);
        tick();
        exp_e = sb.pop_front(); act = idex_now(); n_checks++;
        if (act !== exp_e) begin n_fail++; $display("FAIL bgtz_cap: got %h want %h", act, exp_e); end
        idle();
    endtask

    task automatic test_reg0_flush();
        in_valid = 1'b1; is_branch = 1'b1; in_instr = mk(6'b000100, 5'd0, 5'd1, 16'h0008);
        mem_reg_write = 1'b1; mem_dst = 5'd0; mem_alu = 32'd3;
        #1;
        n_checks++;
        if (pc_src !== 1'b0) begin n_fail++; $display("FAIL fwd_reg0: got %b want 0", pc_src); end
        is_branch = 1'b0; mem_reg_write = 1'b0; mem_alu = '0;
        wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD;
        in_instr = mk(6'd0, 5'd0, 5'd0, 16'h0000); in_pc = 32'h300; ctrl_in = 16'h3333;
        push_cap(32'h300, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 16'h3333);
        tick();
        exp_e = sb.pop_front(); act = idex_now(); n_checks++;
        if (act !== exp_e) begin n_fail++; $display("FAIL reg0_wb_bypass: got %h want %h", act, exp_e); end
        wb_we = 1'b0; in_pc = 32'h304; ctrl_in = 16'h4444;
        push_cap(32'h304, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 16'h4444);
        tick();
        exp_e = sb.pop_front(); act = idex_now(); n_checks++;
        if (act !== exp_e) begin n_fail++; $display("FAIL reg0_read: got %h want %h", act, exp_e); end
        in_instr = mk(6'd0, 5'd1, 5'd3, 16'h0800); in_pc = 32'h308; ctrl_in = 16'h5555; flush_ex = 1'b1;
        push_bubble();
        tick();
        exp_e = sb.pop_front(); act = idex_now(); n_checks++;
        if (act !== exp_e) begin n_fail++; $display("FAIL flush: got %h want %h", act, exp_e); end
        idle();
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; in_instr = mk(6'd0, 5'd1, 5'd3, 16'h5000); in_pc = 32'h400; ctrl_in = 16'h7777;
        push_cap(32'h400, 32'd3, 32'hFFFF_FFFF, 32'h5000, 5'd1, 5'd3, 5'd10, 16'h7777);
        tick();
        exp_e = sb.pop_front(); act = idex_now(); n_checks++;
        if (act !== exp_e) begin n_fail++; $display("FAIL pre_reset_cap: got %h want %h", act, exp_e); end
        ex_mem_read = 1'b1; ex_dst = 5'd1;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL stall_before_reset: got %b want 1", stall); end
        #1;
        rst_n = 1'b0;
        #1;
        act = idex_now(); n_checks++;
        if (act !== '0) begin n_fail++; $display("FAIL async_reset_clear: got %h want 0", act); end
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL stall_release: got %b want 0", stall); end
`ifdef ID_STAGE_PERF_EN
        n_checks++;
        if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL perf_reset: got %0d want 0", stall_cnt); end
`endif
        idle();
        last = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; in_instr = mk(6'd0, 5'd1, 5'd8, 16'h0000); in_pc = 32'h500; ctrl_in = 16'h0001;
        push_cap(32'h500, 32'd0, 32'd0, 32'd0, 5'd1, 5'd8, 5'd0, 16'h0001);
        tick();
        exp_e = sb.pop_front(); act = idex_now(); n_checks++;
        if (act !== exp_e) begin n_fail++; $display("FAIL rf_after_reset: got %h want %h", act, exp_e); end
        idle();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_load_use();
        test_beq_fwd();
        test_bgtz();
        test_reg0_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_stage_hz.md
Name: id_stage_hz

Overview:
- Parametrised successor decode stage for the pipelined MIPS core. Sits between the IF/ID latch and the EX stage.
- Contains the register file, ID-stage branch resolution with internal forwarding, and the load-use/branch hazard detection that drives `stall`.
- Contains the ID/EX pipeline register with bubble insertion and flush.
- Operand width, register count, PC width and control-bundle width are parameters.

Parameters:
- DATA_W, 32, register/operand width.
- NUM_REGS, 32, register-file entries; register 0 reads as zero; must be a power of two ≤ 32.
- REG_AW, 5, register index width (log2 NUM_REGS).
- ADDR_W, 32, PC width.
- CTRL_W, 16, width of the pre-decoded control bundle from the control unit, passed through to EX.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  IF/ID holds a real instruction.
- in_instr  in  32  instruction word: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0].
- in_pc  in  ADDR_W  PC+4 of the instruction.
- ctrl_in  in  CTRL_W  decoded control bundle.
- is_branch  in  1  control unit: instruction is a conditional branch.
- wb_we  in  1  writeback enable.
- wb_addr  in  REG_AW  writeback register index.
- wb_data  in  DATA_W  writeback data.
- ex_reg_write  in  1  instruction in EX writes a register.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_dst  in  REG_AW  destination register of the instruction in EX.
- mem_reg_write  in  1  instruction in MEM writes a register.
- mem_mem_read  in  1  instruction in MEM is a load.
- mem_dst  in  REG_AW  destination register of the instruction in MEM.
- mem_alu  in  DATA_W  ALU result held in EX/MEM.
- flush_ex  in  1  squash the ID/EX contents.
- stall  out  1  hold PC and IF/ID (combinational).
- pc_src  out  1  branch taken (combinational).
- branch_target  out  ADDR_W  in_pc + (sext(imm) << 2).
- out_valid  out  1  ID/EX holds a real instruction.
- out_pc  out  ADDR_W  registered PC+4.
- out_rs_data  out  DATA_W  registered rs operand.
- out_rt_data  out  DATA_W  registered rt operand.
- out_imm  out  DATA_W  registered sign-extended immediate.
- out_rs  out  REG_AW  registered rs index.
- out_rt  out  REG_AW  registered rt index.
- out_rd  out  REG_AW  registered rd index.
- out_ctrl  out  CTRL_W  registered control bundle.

Behaviour:
- Reset: all registers and every registered output go to 0 immediately on rst_n low; out_valid=0.
- Register file: write on clk edge when wb_we and wb_addr≠0; writes to index 0 are ignored.
- Register file read bypass: if wb_we, wb_addr==rs/rt and index≠0, the read returns wb_data in the same cycle.
- Hazard match: a register "matches" when its index equals rs or rt and the index ≠ 0.
- Load-use stall: ex_mem_read and ex_dst matches.
- Branch stalls (only when is_branch):
  - ex_reg_write and ex_dst matches (1 cycle);
  - mem_mem_read and mem_dst matches (second load cycle).
- stall = in_valid and (any stall condition).
- Branch compare forwarding: per operand, use mem_alu when mem_reg_write, not mem_mem_read, and mem_dst matches (≠0); otherwise use the bypassed register-file value.
- Branch modes by opcode:
  - 000100 BEQ: a==b;
  - 000101 BNE: a≠b;
  - 000110 BLEZ: signed a≤0;
  - 000111 BGTZ: signed a>0;
  - any other opcode with is_branch: not taken.
- pc_src = in_valid and is_branch and !stall and condition true.
- branch_target: combinational; imm sign-extended to ADDR_W and shifted by 2; wraps modulo 2^ADDR_W.
- ID/EX update each clk edge, in priority order:
  1. flush_ex → bubble;
  2. else stall or !in_valid → bubble;
  3. else capture in_pc, operands (bypassed register-file values, not branch-forwarded), sign-extended imm (to DATA_W), rs/rt/rd, ctrl_in; out_valid=1.
- Bubble: out_valid=0 and out_ctrl=0; other fields hold their previous values.
- Latency: 1 cycle from ID to EX.
- Simultaneous writeback to a register being read during a stall: the register-file value is updated and visible in the next cycle's re-decode.
- Reset asserted mid-stall: stall releases once in_valid is driven low by the upstream reset; ID/EX is cleared.

Optional Feature:
- Macro: ID_STAGE_PERF_EN.
- When defined, adds outputs:
  - stall_cnt  out  32  cycles with stall=1;
  - br_taken_cnt  out  32  cycles with pc_src=1.
- Both counters reset to 0 on rst_n, saturate at 0xFFFFFFFF and never wrap.
- When not defined: no counters and no extra ports; the block is otherwise identical.

Test Plan:
- Writeback bypass: wb_we=1, wb_addr=5, wb_data=0x1234 while decoding rs=5 → same-cycle read 0x1234; next edge out_rs_data=0x1234, out_valid=1.
- Load-use: ex_mem_read=1, ex_dst=8, decode rt=8 → stall=1 and bubble (out_valid=0, out_ctrl=0); drop ex_mem_read → stall=0 and capture.
- BEQ forwarding: reg1=3, mem_reg_write=1, mem_dst=2, mem_alu=3, BEQ rs=1 rt=2, imm=0x0004, in_pc=0x100 → pc_src=1, branch_target=0x110.
- BGTZ with negative imm: rs holds 0xFFFFFFFF → pc_src=0; rs holds 1, imm=0xFFFF, in_pc=0x200 → pc_src=1, branch_target=0x1FC.
- Register 0 and flush: wb to register 0 with 0xDEAD → reads 0; flush_ex together with a valid capture → out_valid=0.
- Asynchronous reset mid-operation: rst_n low between edges → all outputs 0 at once (and stall_cnt=0 when ID_STAGE_PERF_EN is defined).
